// File: rtl/int_priority_sched.sv
// Seven-source fixed-priority interrupt scheduler: synchronised edge capture into a
// pending register, masked grant on SCAN, acknowledge timeout and service tracking.
module int_priority_sched #(
  parameter logic [7:0] ACK_TMO = 8'd255
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic [6:0] INTR,
  input  logic       SCAN,
  input  logic       INH,
  input  logic       MASK_WR,
  input  logic [6:0] MASK_D,
  input  logic       INT_ACK,
  input  logic       INT_DONE,
  output logic       SINT,
  output logic [2:0] INT_CODE,
  output logic       INT_BUSY,
  output logic [6:0] PEND,
  output logic [6:0] MASK,
  output logic       TMO_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;
  logic [6:0] sync3_q, sync3_d;
  logic [6:0] rise_q, rise_d;
  logic [6:0] armed_q, armed_d;
  logic [1:0] fill_q, fill_d;
  logic [6:0] pend_q, pend_d;
  logic [6:0] mask_reg_q, mask_reg_d;
  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       sint_q, sint_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;

  logic       fill_done;
  logic [6:0] eligible;
  logic [6:0] pend_clr;
  logic [2:0] pick;

  // A line is armed only after it has been seen low once the synchroniser holds
  // real post-reset samples, so a line held high through reset is not an edge.
  always_comb begin
    fill_done = (fill_q == 2'd2);
    sync1_d   = INTR;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    fill_d    = fill_done ? fill_q : fill_q + 2'd1;
    armed_d   = armed_q | (~sync2_q & {7{fill_done}});
    rise_d    = sync2_q & ~sync3_q & armed_q;
  end

  always_comb begin
    eligible = pend_q & ~mask_reg_q;
    pick     = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (eligible[i]) pick = 3'(i + 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    sint_d   = sint_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    pend_clr = 7'd0;
    case (state_q)
      IDLE: begin
        if (SCAN && !INH && (pick != 3'd0)) begin
          state_d = REQ;
          code_d  = pick;
          sint_d  = 1'b1;
          cnt_d   = ACK_TMO;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          state_d  = SERV;
          pend_clr = 7'd1 << (code_q - 3'd1);
          sint_d   = 1'b0;
          busy_d   = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          sint_d  = 1'b0;
          code_d  = 3'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SERV: begin
        if (INT_DONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          code_d  = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge wins over the acknowledge clear of the same bit.
  always_comb begin
    pend_d     = (pend_q & ~pend_clr) | rise_q;
    mask_reg_d = MASK_WR ? MASK_D : mask_reg_q;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      sync1_q    <= 7'd0;
      sync2_q    <= 7'd0;
      sync3_q    <= 7'd0;
      rise_q     <= 7'd0;
      armed_q    <= 7'd0;
      fill_q     <= 2'd0;
      pend_q     <= 7'd0;
      mask_reg_q <= 7'h7F;
      state_q    <= IDLE;
      code_q     <= 3'd0;
      sint_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      rise_q     <= rise_d;
      armed_q    <= armed_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      mask_reg_q <= mask_reg_d;
      state_q    <= state_d;
      code_q     <= code_d;
      sint_q     <= sint_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign SINT     = sint_q;
  assign INT_CODE = code_q;
  assign INT_BUSY = busy_q;
  assign PEND     = pend_q;
  assign MASK     = mask_reg_q;
  assign TMO_ERR  = tmo_q;

endmodule
